// File: rtl/div_unit.sv
// div_unit: iterative restoring radix-2 divider for DIV/DIVU/MOD/MODU, start/busy/done handshake.
// Define DIV_EARLY_OUT_EN to skip the iteration when |a| < |b| (data-dependent latency).
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] dvd, dvs, rem, amag, bmag, diff;
  logic [WIDTH:0] trial;
  logic [CNT_W-1:0] cnt;
  logic neg_q, neg_r, accept, bz, early, ge;
  assign bz = b == '0;
  // a zero divisor keeps the raw dividend so the remainder comes back as a unchanged
  assign amag = (op_signed && a[WIDTH-1] && !bz) ? -a : a;
  assign bmag = (op_signed && b[WIDTH-1]) ? -b : b;
  assign accept = state == IDLE && start && !flush;
`ifdef DIV_EARLY_OUT_EN
  assign early = !bz && amag < bmag;
`else
  assign early = 1'b0;
`endif
  assign trial = {rem, dvd[WIDTH-1]};
  assign ge = trial >= {1'b0, dvs};
  assign diff = trial[WIDTH-1:0] - dvs;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (flush && state != IDLE) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = accept ? (early ? FIX : CALC) : IDLE;
        CALC: state_nx = cnt == '0 ? FIX : CALC;
        FIX:  state_nx = DONE;
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q <= '0;
      r <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      dvd <= early ? '0 : amag;
      rem <= early ? amag : '0;
      dvs <= bmag;
      cnt <= CNT_W'(WIDTH - 1);
      neg_q <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= op_signed & a[WIDTH-1];
      div_zero <= bz;
    end else if (state == CALC) begin
      rem <= ge ? diff : trial[WIDTH-1:0];
      dvd <= {dvd[WIDTH-2:0], ge};
      cnt <= cnt - 1'b1;
    end else if (state == FIX && !flush) begin
      q <= (neg_q && !div_zero) ? -dvd : dvd;
      r <= (neg_r && !div_zero) ? -rem : rem;
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against a plain-arithmetic reference.
module tb_div_unit;
  logic clk = 0, rst_n = 0, start = 0, op_signed = 0, flush = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done, div_zero;
  logic [31:0] q, r;
  int checks = 0, errors = 0;
  logic [31:0] last_q = 0, last_r = 0;

  div_unit dut (.clk(clk), .rst_n(rst_n), .start(start), .op_signed(op_signed), .a(a), .b(b),
                .flush(flush), .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint absl(input longint x);
    return x < 0 ? -x : x;
  endfunction

  function automatic void model(input logic [31:0] ta, input logic [31:0] tb_, input logic sg,
                                output logic [31:0] eq, output logic [31:0] er, output int lat);
    longint sa, sb, lq, lr;
    sa = sg ? longint'($signed(ta)) : longint'(ta);
    sb = sg ? longint'($signed(tb_)) : longint'(tb_);
    if (tb_ == 0) begin
      eq = 32'hFFFF_FFFF;
      er = ta;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      eq = lq[31:0];
      er = lr[31:0];
    end
    lat = 34;
`ifdef DIV_EARLY_OUT_EN
    if (tb_ != 0 && absl(sa) < absl(sb)) lat = 2;
`endif
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic sg);
    logic [31:0] eq, er;
    int el, k;
    logic bok;
    model(ta, tb_, sg, eq, er, el);
    @(negedge clk);
    start = 1; a = ta; b = tb_; op_signed = sg;
    @(negedge clk);
    start = 0; k = 1; bok = 1;
    while (!done && k < 80) begin
      bok &= busy;
      @(negedge clk);
      k++;
    end
    bok &= busy;
    chk("latency", k, el);
    chk("busy_window", bok, 1);
    chk("q", q, eq);
    chk("r", r, er);
    chk("div_zero", div_zero, tb_ == 0);
    start = 1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 0;
    chk("idle_after_done", {busy, done}, 0);
    last_q = eq; last_r = er;
  endtask

  initial begin
    logic seen;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, done, div_zero, q, r}, 0);
    rst_n = 1;
    run_op(32'd100, 32'd7, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1);
    run_op(32'd7, 32'hFFFF_FFFE, 1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    run_op(32'h8000_0005, 32'd0, 1);
    run_op(32'd3, 32'd10, 0);
    run_op(32'hFFFF_FFFD, 32'd10, 1);
    run_op(32'd20, 32'd3, 1);
    // flush mid-operation, with an ignored start while busy
    @(negedge clk);
    start = 1; a = 32'd50; b = 32'd5; op_signed = 0;
    @(negedge clk);
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      seen |= done;
      start = (k == 5);
      if (k == 5) begin a = 32'd1000; b = 32'd3; end
      flush = (k == 10);
      @(negedge clk);
    end
    flush = 0; start = 0;
    chk("flush_busy", busy, 0);
    chk("flush_q", q, last_q);
    chk("flush_r", r, last_r);
    for (int k = 0; k < 5; k++) begin
      seen |= done | busy;
      @(negedge clk);
    end
    chk("flush_quiet", seen, 0);
    start = 1; flush = 1; a = 32'd9; b = 32'd4;
    @(negedge clk);
    start = 0; flush = 0;
    chk("flush_beats_start", busy, 0);
    run_op(32'd9, 32'd4, 0);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 6))
        0: rb = 0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        4: ra = $urandom_range(0, 20);
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end
    run_op(32'd9, 32'd4, 0);
    // asynchronous reset in the middle of an operation
    @(negedge clk);
    start = 1; a = 32'd1000; b = 32'd3; op_signed = 0;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("async_reset", {busy, done, div_zero, q, r}, 0);
    @(negedge clk);
    rst_n = 1;
    run_op(32'd3, 32'd10, 0);
    run_op(32'd1000, 32'd3, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
